pe_operand_join: RTL and testbench



---
 rtl/pe_operand_join_pkg.sv | 24 ++
 rtl/pe_operand_join_if.sv | 33 +++
 rtl/pe_operand_fifo.sv | 53 +++++
 rtl/pe_operand_join.sv | 131 +++++++++++++
 tb/tb_pe_operand_join.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_operand_join_pkg.sv
// Shared constants and types for the PE operand-join stage (package pe_pkg).
// Optional constant-operand build is selected with PE_OPERAND_CONST_EN.
package pe_pkg;

    localparam int NUM_OPERANDS        = 3;
    localparam int OP1                 = 0;
    localparam int OP2                 = 1;
    localparam int OP3                 = 2;
    localparam int CONST_WIDTH_DEFAULT = 8;

    typedef logic [NUM_OPERANDS-1:0] need_mask_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // A set is complete when at least one operand is required and every
    // required operand is present; an empty mask never completes.
    function automatic logic required_ok(input need_mask_t need, input need_mask_t present);
        return (need != '0) && ((present | ~need) == '1);
    endfunction

endpackage

// File: rtl/pe_operand_join_if.sv
// Operand channels into, and the matched operand set out of, pe_operand_join.
// master = upstream producers plus the ALU consumer; slave = the join stage.
interface pe_operand_join_if #(
    parameter int WIDTH = 32
) ();

    logic [WIDTH-1:0] in1_data;
    logic             in1_valid;
    logic             in1_ready;
    logic [WIDTH-1:0] in2_data;
    logic             in2_valid;
    logic             in2_ready;
    logic             in3_data;
    logic             in3_valid;
    logic             in3_ready;

    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic             out_data3;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in1_data, in1_valid, in2_data, in2_valid, in3_data, in3_valid, out_ready,
        input  in1_ready, in2_ready, in3_ready, out_data1, out_data2, out_data3, out_valid
    );

    modport slave (
        input  in1_data, in1_valid, in2_data, in2_valid, in3_data, in3_valid, out_ready,
        output in1_ready, in2_ready, in3_ready, out_data1, out_data2, out_data3, out_valid
    );

endinterface

// File: rtl/pe_operand_fifo.sv
// Per-operand FIFO: DEPTH entries (power of two), wrapping pointers, occupancy count.
// Push is ignored when full and pop is ignored when empty.
module pe_operand_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

    // Head entry is read combinationally so a fire can load the output
    // register in the same cycle the last required operand becomes present.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_reg];

endmodule

// File: rtl/pe_operand_join.sv
// Collects the ALU operands from three valid/ready channels and presents each
// complete set from a registered output stage. Optional: PE_OPERAND_CONST_EN.
module pe_operand_join
    import pe_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 2,
    parameter int CONST_WIDTH = CONST_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  need_mask_t             need_mask,
`ifdef PE_OPERAND_CONST_EN
    input  logic                   const_en,
    input  logic [CONST_WIDTH-1:0] constant,
`endif
    pe_operand_join_if.slave       bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    need_mask_t       in_valid;
    need_mask_t       in_ready;
    need_mask_t       push;
    need_mask_t       pop;
    need_mask_t       full;
    need_mask_t       empty;
    need_mask_t       present;
    need_mask_t       chan_en;
    logic [CW-1:0]    count [NUM_OPERANDS];
    logic             unused_count;

    logic             const_sel;
    logic [WIDTH-1:0] const_ext;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             rd3;
    logic             fire;

    out_state_e       state_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data1_reg;
    logic [WIDTH-1:0] out_data2_reg;
    logic             out_data3_reg;

`ifdef PE_OPERAND_CONST_EN
    assign const_sel = const_en;
    assign const_ext = WIDTH'($signed(constant));
`else
    assign const_sel = 1'b0;
    assign const_ext = '0;
`endif

    assign in_valid      = {bus.in3_valid, bus.in2_valid, bus.in1_valid};
    assign bus.in1_ready = in_ready[OP1];
    assign bus.in2_ready = in_ready[OP2];
    assign bus.in3_ready = in_ready[OP3];

    // A channel replaced by the constant is idle: never ready, never popped,
    // and counted as present so it cannot block a fire.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPERANDS; gi++) begin : g_chan
            assign chan_en[gi]  = !((gi == OP2) && const_sel);
            assign in_ready[gi] = !full[gi] && chan_en[gi];
            assign push[gi]     = in_valid[gi] && in_ready[gi];
            assign present[gi]  = !empty[gi] || !chan_en[gi];
            assign pop[gi]      = fire && need_mask[gi] && chan_en[gi];
        end
    endgenerate

    assign unused_count = ^{count[OP1], count[OP2], count[OP3]};

    pe_operand_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .rst(rst), .push(push[OP1]), .pop(pop[OP1]), .wr_data(bus.in1_data),
        .rd_data(rd1), .full(full[OP1]), .empty(empty[OP1]), .count(count[OP1])
    );

    pe_operand_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
        .clk(clk), .rst(rst), .push(push[OP2]), .pop(pop[OP2]), .wr_data(bus.in2_data),
        .rd_data(rd2), .full(full[OP2]), .empty(empty[OP2]), .count(count[OP2])
    );

    pe_operand_fifo #(.WIDTH(1), .DEPTH(DEPTH)) u_fifo3 (
        .clk(clk), .rst(rst), .push(push[OP3]), .pop(pop[OP3]), .wr_data(bus.in3_data),
        .rd_data(rd3), .full(full[OP3]), .empty(empty[OP3]), .count(count[OP3])
    );

    assign fire = required_ok(need_mask, present) && ((state_reg == OUT_EMPTY) || bus.out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= OUT_EMPTY;
            out_valid_reg <= 1'b0;
            out_data1_reg <= '0;
            out_data2_reg <= '0;
            out_data3_reg <= 1'b0;
        end else begin
            // Payload only changes on a fire, so it is stable during a stall.
            if (fire) begin
                out_data1_reg <= need_mask[OP1] ? rd1 : '0;
                out_data2_reg <= const_sel ? const_ext : (need_mask[OP2] ? rd2 : '0);
                out_data3_reg <= need_mask[OP3] && rd3;
            end
            case (state_reg)
                OUT_EMPTY: begin
                    if (fire) begin
                        state_reg     <= OUT_FULL;
                        out_valid_reg <= 1'b1;
                    end
                end
                OUT_FULL: begin
                    if (!fire && bus.out_ready) begin
                        state_reg     <= OUT_EMPTY;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= OUT_EMPTY;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data1 = out_data1_reg;
    assign bus.out_data2 = out_data2_reg;
    assign bus.out_data3 = out_data3_reg;

endmodule

// File: tb/tb_pe_operand_join.sv
// Randomised bench for pe_operand_join against a queue-based operand-set model.
// Constant-operand scenario is included when PE_OPERAND_CONST_EN is defined.
module tb_pe_operand_join;
    import pe_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    need_mask_t need_mask = 3'b011;
`ifdef PE_OPERAND_CONST_EN
    logic       const_en = 1'b0;
    logic [7:0] constant = 8'h00;
`endif

    pe_operand_join_if #(.WIDTH(WIDTH)) bus ();

    pe_operand_join #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CONST_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .need_mask (need_mask),
`ifdef PE_OPERAND_CONST_EN
        .const_en  (const_en),
        .constant  (constant),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: one queue per operand channel plus the presented operand set.
    logic [31:0] mq1 [$];
    logic [31:0] mq2 [$];
    logic        mq3 [$];
    logic        m_ov;
    logic [31:0] m_d1, m_d2;
    logic        m_d3;
    logic        m_const = 1'b0;
    logic [7:0]  m_cval  = 8'h00;
    logic [2:0]  m_rdy;
    logic [2:0]  m_acc;

    function automatic logic [31:0] sext8(input logic [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

    task automatic model_ready();
        m_rdy[0] = mq1.size() < DEPTH;
        m_rdy[1] = !m_const && (mq2.size() < DEPTH);
        m_rdy[2] = mq3.size() < DEPTH;
    endtask

    task automatic do_reset(input logic [2:0] mask, input logic cen, input logic [7:0] cval);
        rst = 1'b1;
        bus.in1_valid = 1'b0; bus.in2_valid = 1'b0; bus.in3_valid = 1'b0;
        bus.in1_data = '0; bus.in2_data = '0; bus.in3_data = 1'b0;
        bus.out_ready = 1'b0;
        need_mask = mask;
        m_const = cen;
        m_cval  = cval;
`ifdef PE_OPERAND_CONST_EN
        const_en = cen;
        constant = cval;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq1.delete(); mq2.delete(); mq3.delete();
        m_ov = 1'b0; m_d1 = '0; m_d2 = '0; m_d3 = 1'b0;
        model_ready();
    endtask

    // Drive one cycle, advance the model across the edge, return 1 ns after it.
    task automatic step(input logic v1, input logic [31:0] d1, input logic v2, input logic [31:0] d2,
                        input logic v3, input logic d3, input logic ordy);
        logic ok;
        logic [2:0] acc;
        bus.in1_valid = v1; bus.in1_data = d1;
        bus.in2_valid = v2; bus.in2_data = d2;
        bus.in3_valid = v3; bus.in3_data = d3;
        bus.out_ready = ordy;
        acc = {v3 && m_rdy[2], v2 && m_rdy[1], v1 && m_rdy[0]};
        ok = (need_mask != 3'b000) && (!m_ov || ordy);
        if (need_mask[0] && mq1.size() == 0) ok = 1'b0;
        if (need_mask[1] && !m_const && mq2.size() == 0) ok = 1'b0;
        if (need_mask[2] && mq3.size() == 0) ok = 1'b0;
        if (ok) begin
            m_ov = 1'b1;
            m_d1 = 32'd0; m_d2 = 32'd0; m_d3 = 1'b0;
            if (need_mask[0]) m_d1 = mq1.pop_front();
            if (m_const) m_d2 = sext8(m_cval);
            else if (need_mask[1]) m_d2 = mq2.pop_front();
            if (need_mask[2]) m_d3 = mq3.pop_front();
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        if (acc[0]) mq1.push_back(d1);
        if (acc[1]) mq2.push_back(d2);
        if (acc[2]) mq3.push_back(d3);
        m_acc = acc;
        model_ready();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset(3'b011, 1'b0, 8'h00);
        n_vec++;
        if ({bus.out_valid, bus.in3_ready, bus.in2_ready, bus.in1_ready} !== 4'b0111) begin
            n_err++;
            $display("FAIL reset_ctrl got v/rdy=%b%b%b%b need 0111", bus.out_valid,
                     bus.in3_ready, bus.in2_ready, bus.in1_ready);
        end
        n_vec++;
        if ({bus.out_data1, bus.out_data2, bus.out_data3} !== 65'd0) begin
            n_err++;
            $display("FAIL reset_data got %h/%h/%b need 0/0/0", bus.out_data1, bus.out_data2, bus.out_data3);
        end
        for (int i = 0; i < 3; i++) begin
            step(i == 0, 32'h1234, 1'b0, '0, 1'b0, 1'b0, 1'b1);
            n_vec++;
            if (bus.out_valid !== 1'b0 || {bus.in3_ready, bus.in2_ready, bus.in1_ready} !== m_rdy) begin
                n_err++;
                $display("FAIL in1_only cyc %0d got v=%b rdy=%b need v=0 rdy=%b", i, bus.out_valid,
                         {bus.in3_ready, bus.in2_ready, bus.in1_ready}, m_rdy);
            end
        end
    endtask

    task automatic test_latency();
        do_reset(3'b011, 1'b0, 8'h00);
        step(1'b1, 32'd5, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 32'd7, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early got out_valid=%b need 0", bus.out_valid);
        end
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({bus.out_valid, bus.out_data1, bus.out_data2, bus.out_data3} !== {1'b1, 32'd5, 32'd7, 1'b0}) begin
            n_err++;
            $display("FAIL latency_set got v=%b %h/%h/%b need v=1 5/7/0", bus.out_valid,
                     bus.out_data1, bus.out_data2, bus.out_data3);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] seen [$];
        do_reset(3'b011, 1'b0, 8'h00);
        step(1'b1, 32'h11, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (bus.in1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full got in1_ready=%b need 0", bus.in1_ready);
        end
        step(1'b1, 32'h33, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h33, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h33, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({bus.out_valid, bus.in1_ready} !== {m_ov, m_rdy[0]} || m_acc[0] !== 1'b1) begin
            n_err++;
            $display("FAIL bp_third got v=%b rdy1=%b need v=%b rdy1=%b", bus.out_valid, bus.in1_ready,
                     m_ov, m_rdy[0]);
        end
        if (bus.out_valid) seen.push_back(bus.out_data1);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, '0, k < 2, 32'h200 + k, 1'b0, 1'b0, 1'b1);
            n_vec++;
            if ({bus.out_valid, bus.in3_ready, bus.in2_ready, bus.in1_ready} !== {m_ov, m_rdy} ||
                (m_ov && {bus.out_data1, bus.out_data2} !== {m_d1, m_d2})) begin
                n_err++;
                $display("FAIL bp_drain cyc %0d got v=%b %h/%h need v=%b %h/%h", k, bus.out_valid,
                         bus.out_data1, bus.out_data2, m_ov, m_d1, m_d2);
            end
            if (bus.out_valid && (seen.size() == 0 || seen[$] !== bus.out_data1)) seen.push_back(bus.out_data1);
        end
        n_vec++;
        if (seen.size() != 3 || seen[0] !== 32'h11 || seen[1] !== 32'h22 || seen[2] !== 32'h33) begin
            n_err++;
            $display("FAIL bp_order got %0d sets %p need 11,22,33", seen.size(), seen);
        end
    endtask

    task automatic test_stream();
        logic [31:0] p1, p2;
        logic        p3, ordy, prev_stall;
        logic [64:0] prev_data;
        int          n_valid;
        do_reset(3'b111, 1'b0, 8'h00);
        p1 = $urandom; p2 = $urandom; p3 = 1'($urandom);
        n_valid = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int i = 0; i < 56; i++) begin
            ordy = (i < 40) ? 1'b1 : ((i % 2) == 0);
            step(1'b1, p1, 1'b1, p2, 1'b1, p3, ordy);
            if (m_acc[0]) p1 = $urandom;
            if (m_acc[1]) p2 = $urandom;
            if (m_acc[2]) p3 = 1'($urandom);
            if (i < 40 && bus.out_valid) n_valid++;
            n_vec++;
            if ({bus.out_valid, bus.in3_ready, bus.in2_ready, bus.in1_ready} !== {m_ov, m_rdy} ||
                (m_ov && {bus.out_data1, bus.out_data2, bus.out_data3} !== {m_d1, m_d2, m_d3})) begin
                n_err++;
                $display("FAIL stream cyc %0d got v=%b %h/%h/%b need v=%b %h/%h/%b", i, bus.out_valid,
                         bus.out_data1, bus.out_data2, bus.out_data3, m_ov, m_d1, m_d2, m_d3);
            end
            if (prev_stall) begin
                n_vec++;
                if ({bus.out_data1, bus.out_data2, bus.out_data3} !== prev_data || bus.out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall_hold cyc %0d got %h need %h", i,
                             {bus.out_data1, bus.out_data2, bus.out_data3}, prev_data);
                end
            end
            prev_stall = bus.out_valid && (i >= 39) && ((i + 1) % 2 != 0);
            prev_data  = {bus.out_data1, bus.out_data2, bus.out_data3};
        end
        n_vec++;
        if (n_valid !== 39) begin
            n_err++;
            $display("FAIL throughput got %0d valid cycles need 39", n_valid);
        end
    endtask

    task automatic test_random();
        logic [2:0]  masks [8] = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111, 3'b011, 3'b000};
        logic [31:0] p1, p2;
        logic        p3;
        logic [2:0]  v;
        for (int m = 0; m < 8; m++) begin
            do_reset(masks[m], 1'b0, 8'h00);
            v = 3'b000;
            p1 = $urandom; p2 = $urandom; p3 = 1'($urandom);
            for (int i = 0; i < 30; i++) begin
                // Valid is held until accepted, and only required channels are driven.
                for (int c = 0; c < 3; c++)
                    if (!v[c]) v[c] = masks[m][c] && ($urandom_range(0, 2) != 0);
                step(v[0], p1, v[1], p2, v[2], p3, 1'($urandom));
                if (m_acc[0]) begin v[0] = 1'b0; p1 = $urandom; end
                if (m_acc[1]) begin v[1] = 1'b0; p2 = $urandom; end
                if (m_acc[2]) begin v[2] = 1'b0; p3 = 1'($urandom); end
                n_vec++;
                if ({bus.out_valid, bus.in3_ready, bus.in2_ready, bus.in1_ready} !== {m_ov, m_rdy} ||
                    (m_ov && {bus.out_data1, bus.out_data2, bus.out_data3} !== {m_d1, m_d2, m_d3})) begin
                    n_err++;
                    $display("FAIL random mask=%b cyc %0d got v=%b %h/%h/%b need v=%b %h/%h/%b", masks[m], i,
                             bus.out_valid, bus.out_data1, bus.out_data2, bus.out_data3, m_ov, m_d1, m_d2, m_d3);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(3'b011, 1'b0, 8'h00);
        step(1'b1, 32'hA, 1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hD, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({bus.out_valid, bus.in1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL pre_reset got v=%b rdy1=%b need v=1 rdy1=0", bus.out_valid, bus.in1_ready);
        end
        rst = 1'b1;
        bus.in1_valid = 1'b0; bus.in2_valid = 1'b0; bus.in3_valid = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if ({bus.out_valid, bus.in3_ready, bus.in2_ready, bus.in1_ready} !== 4'b0111 ||
            {bus.out_data1, bus.out_data2, bus.out_data3} !== 65'd0) begin
            n_err++;
            $display("FAIL mid_reset got v/rdy=%b%b%b%b data=%h need 0111 data=0", bus.out_valid,
                     bus.in3_ready, bus.in2_ready, bus.in1_ready, {bus.out_data1, bus.out_data2, bus.out_data3});
        end
        rst = 1'b0;
        mq1.delete(); mq2.delete(); mq3.delete();
        m_ov = 1'b0; m_d1 = '0; m_d2 = '0; m_d3 = 1'b0;
        model_ready();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, i == 0, 32'hE, 1'b0, 1'b0, 1'b1);
            n_vec++;
            if (bus.out_valid !== 1'b0 || m_ov !== 1'b0) begin
                n_err++;
                $display("FAIL stale cyc %0d got out_valid=%b need 0 (d1=%h)", i, bus.out_valid, bus.out_data1);
            end
        end
        step(1'b1, 32'hF, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if ({bus.out_valid, bus.out_data1, bus.out_data2} !== {1'b1, 32'hF, 32'hE}) begin
            n_err++;
            $display("FAIL post_reset got v=%b %h/%h need v=1 f/e", bus.out_valid, bus.out_data1, bus.out_data2);
        end
    endtask

`ifdef PE_OPERAND_CONST_EN
    task automatic test_const();
        do_reset(3'b011, 1'b1, 8'hF0);
        n_vec++;
        if (bus.in2_ready !== 1'b0) begin
            n_err++;
            $display("FAIL const_rdy got in2_ready=%b need 0", bus.in2_ready);
        end
        step(1'b1, 32'd1, 1'b1, 32'h55, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if ({bus.out_valid, bus.out_data1, bus.out_data2, bus.in2_ready} !== {1'b1, 32'd1, 32'hFFFFFFF0, 1'b0}) begin
            n_err++;
            $display("FAIL const_set got v=%b %h/%h rdy2=%b need v=1 1/fffffff0 rdy2=0", bus.out_valid,
                     bus.out_data1, bus.out_data2, bus.in2_ready);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'($urandom), $urandom, 1'b1, 32'h66, 1'b0, 1'b0, 1'($urandom));
            n_vec++;
            if ({bus.out_valid, bus.in3_ready, bus.in2_ready, bus.in1_ready} !== {m_ov, m_rdy} ||
                (m_ov && {bus.out_data1, bus.out_data2} !== {m_d1, m_d2})) begin
                n_err++;
                $display("FAIL const_rand cyc %0d got v=%b %h/%h need v=%b %h/%h", i, bus.out_valid,
                         bus.out_data1, bus.out_data2, m_ov, m_d1, m_d2);
            end
        end
    endtask
`endif

    initial begin
        bus.in1_valid = 1'b0; bus.in2_valid = 1'b0; bus.in3_valid = 1'b0;
        bus.in1_data = '0; bus.in2_data = '0; bus.in3_data = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_latency();
        test_backpressure();
        test_stream();
        test_random();
        test_reset_mid();
`ifdef PE_OPERAND_CONST_EN
        test_const();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
